// File: rtl/score_disp_ctrl_pkg.sv
// Shared constants and helpers for the score display controller: widths,
// digit-enable patterns, converter state encodings and the shift-add-3 step.
package score_disp_ctrl_pkg;

   localparam int SCORE_W = 11;
   localparam int DIGITS  = 4;

   typedef logic [3:0]             bcd_digit_t;
   typedef logic [DIGITS-1:0][3:0] bcd_word_t;

   typedef enum logic [1:0] {
      SRC_SCORE = 2'd0,
      SRC_HI    = 2'd1,
      SRC_OVER  = 2'd2
   } src_t;

   localparam logic [3:0] AN_DIG0 = 4'b1110;
   localparam logic [3:0] AN_DIG1 = 4'b1101;
   localparam logic [3:0] AN_DIG2 = 4'b1011;
   localparam logic [3:0] AN_DIG3 = 4'b0111;
   localparam logic [3:0] AN_OFF  = 4'b1111;

   localparam logic [1:0] ST_LOAD   = 2'd0;
   localparam logic [1:0] ST_SHIFT  = 2'd1;
   localparam logic [1:0] ST_COMMIT = 2'd2;

   function automatic logic [3:0] an_for_digit(input logic [1:0] idx);
      logic [3:0] pat;
      case (idx)
         2'd0:    pat = AN_DIG0;
         2'd1:    pat = AN_DIG1;
         2'd2:    pat = AN_DIG2;
         default: pat = AN_DIG3;
      endcase
      return pat;
   endfunction

   // Double-dabble correction: any nibble that would overflow past 9 after
   // the next shift gets 3 added first.
   function automatic bcd_word_t bcd_adjust(input bcd_word_t acc);
      bcd_word_t res;
      for (int k = 0; k < DIGITS; k++) begin
         res[k] = (acc[k] >= 4'd5) ? acc[k] + 4'd3 : acc[k];
      end
      return res;
   endfunction

endpackage

// File: rtl/score_disp_ctrl_if.sv
// Game-side bundle for the score display: values and requests in, pins out.
interface score_disp_ctrl_if;
   import score_disp_ctrl_pkg::*;

   logic [SCORE_W-1:0] score;
   logic [SCORE_W-1:0] hi_score;
   logic               show_hi;
   logic               game_over;
   logic [7:0]         seg;
   logic [3:0]         an;

   modport master (output score, hi_score, show_hi, game_over, input seg, an);
   modport slave  (input score, hi_score, show_hi, game_over, output seg, an);

endinterface

// File: rtl/score_disp_ctrl_bin2bcd.sv
// Free-running sequential binary-to-BCD converter (shift-add-3), one result
// every 13 cycles, flagged by a single-cycle commit pulse.
//
// state     | meaning
// ----------+--------------------------------------------------------
// ST_LOAD   | capture input value, clear accumulator, arm bit counter
// ST_SHIFT  | adjust nibbles >= 5, shift in value MSB (11 cycles)
// ST_COMMIT | accumulator is final; commit pulse high for this cycle
module bin2bcd_seq
   import score_disp_ctrl_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic [SCORE_W-1:0] value,
   output bcd_word_t          digits,
   output logic               commit
);

   logic [1:0]          state;
   logic [3:0]          bit_cnt;
   logic [SCORE_W-1:0]  shreg;
   bcd_word_t           acc;
   logic [4*DIGITS-1:0] adj_flat;

   assign adj_flat = bcd_adjust(acc);
   assign digits   = acc;
   assign commit   = (state == ST_COMMIT);

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_LOAD;
         bit_cnt <= '0;
         shreg   <= '0;
         acc     <= '0;
      end else begin
         case (state)
            ST_LOAD: begin
               shreg   <= value;
               acc     <= '0;
               bit_cnt <= 4'(SCORE_W - 1);
               state   <= ST_SHIFT;
            end
            ST_SHIFT: begin
               acc     <= {adj_flat[4*DIGITS-2:0], shreg[SCORE_W-1]};
               shreg   <= {shreg[SCORE_W-2:0], 1'b0};
               bit_cnt <= bit_cnt - 4'd1;
               if (bit_cnt == 4'd0) begin
                  state <= ST_COMMIT;
               end
            end
            ST_COMMIT: begin
               state <= ST_LOAD;
            end
            default: begin
               state <= ST_LOAD;
            end
         endcase
      end
   end

endmodule

// File: rtl/seven_seg_decoder.sv
// BCD digit to seven-segment pattern, active-low {dp, g, f, e, d, c, b, a};
// dp is held off and codes above 9 blank the digit.
module seven_seg_decoder (
   input  logic [3:0] bcd,
   output logic [7:0] seg
);

   always_comb begin
      case (bcd)
         4'd0:    seg = 8'hC0;
         4'd1:    seg = 8'hF9;
         4'd2:    seg = 8'hA4;
         4'd3:    seg = 8'hB0;
         4'd4:    seg = 8'h99;
         4'd5:    seg = 8'h92;
         4'd6:    seg = 8'h82;
         4'd7:    seg = 8'hF8;
         4'd8:    seg = 8'h80;
         4'd9:    seg = 8'h90;
         default: seg = 8'hFF;
      endcase
   end

endmodule

// File: rtl/score_disp_ctrl.sv
// Shares the 4-digit seven-segment display between live score, high score and
// a blinking game-over score; converts to BCD, blanks leading zeros, scans.
module score_disp_ctrl
   import score_disp_ctrl_pkg::*;
#(
   parameter int SCAN_DIV    = 100000,
   parameter int BLINK_TICKS = 200
) (
   input  logic           clk,
   input  logic           rst,
   score_disp_ctrl_if.slave bus
);

   localparam int SCAN_W  = $clog2(SCAN_DIV);
   localparam int BLINK_W = $clog2(BLINK_TICKS + 1);

   src_t               src_sel;
   logic [SCORE_W-1:0] src_value;
   bcd_word_t          conv_digits;
   logic               conv_commit;
   bcd_word_t          disp;
   logic [3:0]         blank;

   logic [SCAN_W-1:0]  scan_cnt;
   logic               scan_tick;
   logic [BLINK_W-1:0] blink_cnt;
   logic [BLINK_W-1:0] blink_cnt_nxt;
   logic               blink_vis;
   logic               blink_vis_nxt;

   logic [1:0]         dig_idx;
   logic [1:0]         dig_idx_nxt;
   bcd_digit_t         bcd;
   logic [3:0]         an_q;
   logic [7:0]         seg_w;

   always_comb begin
      src_sel = SRC_SCORE;
      if (bus.game_over) begin
         src_sel = SRC_OVER;
      end else if (bus.show_hi) begin
         src_sel = SRC_HI;
      end
      src_value = (src_sel == SRC_HI) ? bus.hi_score : bus.score;
   end

   bin2bcd_seq u_conv (
      .clk    (clk),
      .rst    (rst),
      .value  (src_value),
      .digits (conv_digits),
      .commit (conv_commit)
   );

   // Only finished conversions reach the display register, so the scan never
   // sees a half-shifted accumulator.
   always_ff @(posedge clk) begin
      if (rst) begin
         disp <= '0;
      end else if (conv_commit) begin
         disp <= conv_digits;
      end
   end

   always_comb begin
      blank[3] = (disp[3] == 4'd0);
      blank[2] = blank[3] && (disp[2] == 4'd0);
      blank[1] = blank[2] && (disp[1] == 4'd0);
      blank[0] = 1'b0;
   end

   assign scan_tick = (scan_cnt == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         scan_cnt <= '0;
      end else if (scan_tick) begin
         scan_cnt <= SCAN_W'(SCAN_DIV - 1);
      end else begin
         scan_cnt <= scan_cnt - 1'b1;
      end
   end

   // blink_cnt counts slots already shown in the current phase; the toggle
   // lands on the tick that opens the new phase so that slot uses it.
   always_comb begin
      blink_vis_nxt = blink_vis;
      blink_cnt_nxt = blink_cnt;
      if (!bus.game_over) begin
         blink_vis_nxt = 1'b1;
         blink_cnt_nxt = '0;
      end else if (scan_tick) begin
         if (blink_cnt == BLINK_W'(BLINK_TICKS)) begin
            blink_vis_nxt = !blink_vis;
            blink_cnt_nxt = BLINK_W'(1);
         end else begin
            blink_cnt_nxt = blink_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         blink_vis <= 1'b1;
         blink_cnt <= '0;
      end else begin
         blink_vis <= blink_vis_nxt;
         blink_cnt <= blink_cnt_nxt;
      end
   end

   assign dig_idx_nxt = dig_idx + 2'd1;

   always_ff @(posedge clk) begin
      if (rst) begin
         dig_idx <= 2'd3;
         bcd     <= '0;
         an_q    <= AN_OFF;
      end else if (scan_tick) begin
         dig_idx <= dig_idx_nxt;
         bcd     <= disp[dig_idx_nxt];
         an_q    <= (blink_vis_nxt && !blank[dig_idx_nxt]) ? an_for_digit(dig_idx_nxt)
                                                           : AN_OFF;
      end
   end

   seven_seg_decoder u_dec (
      .bcd (bcd),
      .seg (seg_w)
   );

   assign bus.seg = seg_w;
   assign bus.an  = an_q;

endmodule
